imem_loader: RTL and testbench

- Writer side of the instruction-memory interface: takes a byte stream from the debug link and programs instruction RAM word by word.
- The CPU fetch port reads the same word-indexed, 32-bit array, so the loader holds the core in reset while loading.
- Sits between the byte source (UART receiver or JTAG FIFO) and the write port of the RAM-backed instruction memory.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_word_packer.sv | 63 ++++++
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared instruction-memory widths, loader state encoding and
// the ECALL opcode used by benches as a recognisable instruction word.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 20;
  localparam int unsigned IMEM_DATA_W = 32;

  localparam logic [31:0] IMEM_ECALL = 32'h0000_0073;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA,
    LD_CSUM,
    LD_DONE
  } loader_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: collects four little-endian bytes into one instruction
// word and emits a registered one-cycle word_valid pulse with the word,
// one cycle after the fourth byte is taken.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  output logic                   last_byte_o,
  output logic                   word_valid_o,
  output logic [IMEM_DATA_W-1:0] word_o
);

  logic [1:0]             cnt_q, cnt_d;
  logic [IMEM_DATA_W-9:0] asm_q, asm_d;
  logic [IMEM_DATA_W-1:0] word_q, word_d;
  logic                   wv_q, wv_d;

  assign last_byte_o  = (cnt_q == 2'd3);
  assign word_valid_o = wv_q;
  assign word_o       = word_q;

  // Place each byte at its lane; the fourth byte completes the word at once
  always_comb begin
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    word_d = word_q;
    wv_d   = 1'b0;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    asm_d[7:0]   = byte_i;
        2'd1:    asm_d[15:8]  = byte_i;
        2'd2:    asm_d[23:16] = byte_i;
        default: begin
          word_d = {byte_i, asm_q};
          wv_d   = 1'b1;
        end
      endcase
    end
  end

  // Packer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      asm_q  <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      word_q <= word_d;
      wv_q   <= wv_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: programs instruction RAM from a byte stream (16-bit LE word
// count, then 4 LE bytes per word) while holding the CPU in reset.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned       ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned       DATA_W    = IMEM_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [63:0] ADDR_SPAN = 64'd1 << ADDR_W;
  localparam bit          NO_WRAP   = (64'(BASE_ADDR) + 64'(MAX_WORDS)) <= ADDR_SPAN;

  loader_state_e     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       recv_q, recv_d;
  logic [15:0]       wrcnt_q, wrcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        csum_q, csum_d;

  logic                   take;
  logic                   pk_clear;
  logic                   pk_valid;
  logic                   pk_last;
  logic                   pk_word_valid;
  logic [IMEM_DATA_W-1:0] pk_word;
  logic [15:0]            len_full;

  // Data bytes are only requested until every word of the load has arrived
  assign in_ready = (state_q == LD_LEN_LO) || (state_q == LD_LEN_HI) ||
                    (state_q == LD_CSUM) ||
                    ((state_q == LD_DATA) && (recv_q != len_q));
  assign busy     = (state_q != LD_IDLE) && (state_q != LD_DONE);
  assign cpu_hold = busy;
  assign done     = done_q;
  assign err      = err_q;
  assign wr_en    = pk_word_valid;
  assign wr_addr  = addr_q;
  assign wr_data  = pk_word;
  assign take     = in_valid & in_ready;
  assign pk_valid = take & (state_q == LD_DATA);
  assign len_full = {in_data, len_q[7:0]};

  imem_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (pk_clear),
    .byte_valid_i (pk_valid),
    .byte_i       (in_data),
    .last_byte_o  (pk_last),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  // Load sequencing: arm on start, capture count, stream words, finish
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    recv_d   = recv_q;
    wrcnt_d  = wrcnt_q;
    addr_d   = addr_q;
    done_d   = done_q;
    err_d    = err_q;
    csum_d   = csum_q;
    pk_clear = 1'b0;
    case (state_q)
      LD_IDLE, LD_DONE: begin
        if (start) begin
          state_d  = LD_LEN_LO;
          done_d   = 1'b0;
          err_d    = 1'b0;
          recv_d   = 16'd0;
          wrcnt_d  = 16'd0;
          addr_d   = BASE_ADDR;
          csum_d   = 8'h00;
          pk_clear = 1'b1;
        end
      end
      LD_LEN_LO: begin
        if (take) begin
          len_d[7:0] = in_data;
          state_d    = LD_LEN_HI;
        end
      end
      LD_LEN_HI: begin
        if (take) begin
          len_d[15:8] = in_data;
          if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = LD_CSUM;
`else
            state_d = LD_DONE;
            done_d  = 1'b1;
`endif
          end else if (32'(len_full) > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = LD_IDLE;
          end else begin
            state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (take) begin
          csum_d = csum_q ^ in_data;
          if (pk_last) recv_d = recv_q + 16'd1;
        end
        if (pk_word_valid) begin
          addr_d  = addr_q + ADDR_W'(1);
          wrcnt_d = wrcnt_q + 16'd1;
          if (wrcnt_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = LD_CSUM;
`else
            state_d = LD_DONE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CSUM: begin
        if (take) begin
          if (in_data == csum_q) begin
            done_d  = 1'b1;
            state_d = LD_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = LD_IDLE;
          end
        end
      end
`endif
      default: state_d = LD_IDLE;
    endcase
  end

  // Loader state, counters and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      len_q   <= 16'd0;
      recv_q  <= 16'd0;
      wrcnt_q <= 16'd0;
      addr_q  <= BASE_ADDR;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      csum_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      recv_q  <= recv_d;
      wrcnt_q <= wrcnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      csum_q  <= csum_d;
    end
  end

  // The largest accepted load must fit without the word address wrapping
  assert property (@(posedge clk) disable iff (!rst_n) NO_WRAP);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomised loads of imem_loader, checked
// against a stream-level reference model. Honours IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_pkg::*;

  localparam int unsigned       ADDR_W    = IMEM_ADDR_W;
  localparam int unsigned       MAX_WORDS = 1024;
  localparam logic [ADDR_W-1:0] BASE      = '0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    int                c;
  } strobe_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  strobe_t     wq[$];
  int          accq[$];
  logic [7:0]  stim[$];
  logic [31:0] expWords[$];
  logic [ADDR_W-1:0] expAddrs[$];
  bit          expDone;
  bit          expErr;
  bit          doneSeen = 1'b0;
  int          doneCyc = 0;

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (IMEM_DATA_W),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp transfers and strobes
  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted bytes, write strobes and the first cycle done is seen
  always @(negedge clk) begin
    strobe_t s;
    if (wr_en) begin
      s.a = wr_addr;
      s.d = wr_data;
      s.c = cyc;
      wq.push_back(s);
    end
    if (in_valid && in_ready) accq.push_back(cyc);
    if (done && !doneSeen) begin
      doneSeen = 1'b1;
      doneCyc  = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd0);
    checkOutput({tag, " wr_en"},    64'(wr_en),    64'd0);
    checkOutput({tag, " wr_addr"},  64'(wr_addr),  64'(BASE));
    checkOutput({tag, " wr_data"},  64'(wr_data),  64'd0);
    checkOutput({tag, " cpu_hold"}, 64'(cpu_hold), 64'd0);
    checkOutput({tag, " busy"},     64'(busy),     64'd0);
    checkOutput({tag, " done"},     64'(done),     64'd0);
    checkOutput({tag, " err"},      64'(err),      64'd0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte after a random idle gap and wait (bounded) for the transfer
  task automatic applyStimulus(input logic [7:0] b, input int maxGap);
    int gap;
    int waited;
    bit accepted;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    waited   = 0;
    accepted = 1'b0;
    while (!accepted && waited < 100) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      else waited++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("byte accept", 64'(accepted), 64'd1);
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle wait busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] xorOfData(input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int j = 0; j < 4 * n; j++) x = x ^ stim[2 + j];
    return x;
  endfunction

  // Random load of n words, with a correct trailing checksum when enabled
  task automatic makeStim(input int n);
    stim.delete();
    stim.push_back(8'(n % 256));
    stim.push_back(8'(n / 256));
    for (int j = 0; j < 4 * n; j++) stim.push_back(8'($urandom_range(255, 0)));
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(xorOfData(n));
`endif
  endtask

  // Reference model: derive the expected writes and outcome from the stream
  task automatic buildModel();
    int n;
    logic [31:0] w;
    expWords.delete();
    expAddrs.delete();
    n = int'(stim[0]) + 256 * int'(stim[1]);
    expErr = (n > int'(MAX_WORDS));
    if (!expErr) begin
      for (int i = 0; i < n; i++) begin
        w = 32'(stim[2 + 4*i]) + (32'(stim[3 + 4*i]) << 8) +
            (32'(stim[4 + 4*i]) << 16) + (32'(stim[5 + 4*i]) << 24);
        expWords.push_back(w);
        expAddrs.push_back(ADDR_W'((int'(BASE) + i) % (1 << ADDR_W)));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (stim.size() <= 2 + 4*n) expErr = 1'b1;
      else if (stim[2 + 4*n] != xorOfData(n)) expErr = 1'b1;
`endif
    end
    expDone = !expErr;
  endtask

  task automatic checkLoad(input string tag);
    int idx;
    buildModel();
    checkOutput({tag, " strobes"}, 64'(wq.size()), 64'(expWords.size()));
    for (int i = 0; i < expWords.size() && i < wq.size(); i++) begin
      checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(wq[i].a), 64'(expAddrs[i]));
      checkOutput($sformatf("%s data[%0d]", tag, i), 64'(wq[i].d), 64'(expWords[i]));
      idx = 5 + 4*i;
      if (idx < accq.size())
        checkOutput($sformatf("%s lat[%0d]", tag, i), 64'(wq[i].c), 64'(accq[idx] + 1));
    end
    checkOutput({tag, " done"},     64'(done),     64'(expDone));
    checkOutput({tag, " err"},      64'(err),      64'(expErr));
    checkOutput({tag, " cpu_hold"}, 64'(cpu_hold), 64'd0);
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'd0);
    if (expDone && wq.size() > 0)
      checkOutput({tag, " done_lat"}, 64'(doneCyc), 64'(wq[wq.size()-1].c + 1));
  endtask

  // Arm, stream stim (optionally pulsing start mid-stream), then check
  task automatic runLoad(input string tag, input int maxGap, input int midStartAt);
    pulseStart();
    wq.delete();
    accq.delete();
    doneSeen = 1'b0;
    checkOutput({tag, " hold@start"}, 64'(cpu_hold), 64'd1);
    checkOutput({tag, " flags@start"}, 64'({done, err}), 64'd0);
    for (int i = 0; i < stim.size(); i++) begin
      if (i == midStartAt) begin
        pulseStart();
        checkOutput({tag, " busy@midstart"}, 64'(busy), 64'd1);
      end
      applyStimulus(stim[i], maxGap);
    end
    waitIdle(40);
    checkLoad(tag);
  endtask

  initial begin
    $display("[TB] imem_loader bench starting");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word reference program: addi t0,x0,2 then ecall
    stim = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h20, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    // The XOR of these eight data bytes is 0xC2
    stim.push_back(8'hC2);
`endif
    runLoad("two_word", 0, -1);
    if (wq.size() == 2) begin
      checkOutput("two_word w0 const", 64'(wq[0].d), 64'h0020_0293);
      checkOutput("two_word w1 const", 64'(wq[1].d), 64'(IMEM_ECALL));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    stim = '{8'h02, 8'h00, 8'h93, 8'h02, 8'h20, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00, 8'hC0};
    runLoad("csum_bad", 0, -1);
`endif

    // Count one above the limit is rejected before any data
    stim = '{8'h01, 8'h04};
    runLoad("over_max", 1, -1);

    // Three-word loads with randomly gapped in_valid
    for (int k = 0; k < 3; k++) begin
      makeStim(3);
      runLoad($sformatf("gapped%0d", k), 3, -1);
    end

    // start pulsed in the middle of the data phase must be ignored
    makeStim(2);
    runLoad("mid_start", 2, 5);

    // Random sizes and gaps
    for (int k = 0; k < 4; k++) begin
      makeStim(int'($urandom_range(6, 1)));
      runLoad($sformatf("rand%0d", k), int'($urandom_range(3, 0)), -1);
    end

    // Largest accepted count, streamed back-to-back
    makeStim(int'(MAX_WORDS));
    runLoad("max_words", 0, -1);

    // Reset after the fifth data byte, then an empty load
    makeStim(3);
    pulseStart();
    wq.delete();
    accq.delete();
    for (int i = 0; i < 7; i++) applyStimulus(stim[i], 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    checkOutput("midreset strobes", 64'(wq.size()), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    stim = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    runLoad("zero_len", 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
